// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared FSM type and counter sizing for the matmul engine
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    WRITE,
    DONE
  } state_t;

  // A counter over n values needs at least one bit even when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int M_SIZE_DEF = 8;
  localparam int K_SIZE_DEF = 8;
  localparam int N_SIZE_DEF = 8;
  localparam int I_W_DEF    = cnt_width(M_SIZE_DEF);
  localparam int J_W_DEF    = cnt_width(N_SIZE_DEF);
  localparam int K_W_DEF    = cnt_width(K_SIZE_DEF);

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply with wrapping accumulator register
module mac_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] acc_next
);

  logic [DATA_WIDTH-1:0] acc_q, acc_d, product;

  always_comb begin
    product = DATA_WIDTH'($signed(a) * $signed(b));
    acc_d   = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + product;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Exposing the next value lets the engine register z_din on the same edge as the final add.
  assign acc_next = acc_d;

endmodule

// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - Z = X*Y (or Z += X*Y) over registered-read BRAMs
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int M_SIZE     = 8,
  parameter int K_SIZE     = 8,
  parameter int N_SIZE     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  accumulate,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_dout,
  output logic [ADDR_WIDTH-1:0] y_addr,
  input  logic [DATA_WIDTH-1:0] y_dout,
  output logic [ADDR_WIDTH-1:0] z_rd_addr,
  input  logic [DATA_WIDTH-1:0] z_rd_dout,
  output logic [ADDR_WIDTH-1:0] z_wr_addr,
  output logic [DATA_WIDTH-1:0] z_din,
  output logic                  z_wr_en
);

  localparam int I_W = cnt_width(M_SIZE);
  localparam int J_W = cnt_width(N_SIZE);
  localparam int K_W = cnt_width(K_SIZE);
  localparam logic [I_W-1:0] I_LAST = I_W'(M_SIZE - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_SIZE - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(K_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] K_A = ADDR_WIDTH'(K_SIZE);
  localparam logic [ADDR_WIDTH-1:0] N_A = ADDR_WIDTH'(N_SIZE);

  if (K_SIZE < 1 || M_SIZE * K_SIZE > (1 << ADDR_WIDTH) ||
      K_SIZE * N_SIZE > (1 << ADDR_WIDTH) || M_SIZE * N_SIZE > (1 << ADDR_WIDTH)) begin : g_size_check
    $error("matmul_engine: matrix dimensions do not fit the BRAM address space");
  end

  state_t                  state_q, state_d;
  logic [I_W-1:0]          i_q, i_d;
  logic [J_W-1:0]          j_q, j_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    acc_mode_q, acc_mode_d;
  logic                    zcap_q, zcap_d;
  logic [DATA_WIDTH-1:0]   z_prev_q, z_prev_d;
  logic                    busy_q, busy_d, done_q, done_d, z_wr_en_q, z_wr_en_d;
  logic [ADDR_WIDTH-1:0]   x_addr_q, x_addr_d, y_addr_q, y_addr_d;
  logic [ADDR_WIDTH-1:0]   z_rd_addr_q, z_rd_addr_d, z_wr_addr_q, z_wr_addr_d;
  logic [DATA_WIDTH-1:0]   z_din_q, z_din_d;
  logic                    mac_clear, mac_en;
  logic [DATA_WIDTH-1:0]   mac_acc_next;
  logic                    last_elem;

  assign last_elem = (i_q == I_LAST) && (j_q == J_LAST);

  mac_unit #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
    .clock    (clock),
    .reset    (reset),
    .clear    (mac_clear),
    .en       (mac_en),
    .a        (x_dout),
    .b        (y_dout),
    .acc_next (mac_acc_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (k_q == K_LAST) state_d = LAST;
      LAST:    state_d = WRITE;
      WRITE:   state_d = last_elem ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    acc_mode_d = acc_mode_q;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    case (state_q)
      IDLE: begin
        i_d       = '0;
        j_d       = '0;
        k_d       = '0;
        mac_clear = 1'b1;
        if (start) acc_mode_d = accumulate;
      end
      READ: begin
        // Data for address k arrives one cycle later, so the first READ cycle has nothing to add.
        mac_en = (k_q != '0);
        if (k_q != K_LAST) k_d = k_q + 1'b1;
      end
      LAST: mac_en = 1'b1;
      WRITE: begin
        mac_clear = 1'b1;
        k_d       = '0;
        if (j_q == J_LAST) begin
          j_d = '0;
          i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      default: ;
    endcase
    zcap_d   = (state_q == READ) && (k_q == '0);
    z_prev_d = zcap_q ? (acc_mode_q ? z_rd_dout : '0) : z_prev_q;
  end

  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    z_wr_en_d   = (state_q == LAST);
    x_addr_d    = ADDR_WIDTH'(i_d) * K_A + ADDR_WIDTH'(k_d);
    y_addr_d    = ADDR_WIDTH'(k_d) * N_A + ADDR_WIDTH'(j_d);
    z_rd_addr_d = ADDR_WIDTH'(i_d) * N_A + ADDR_WIDTH'(j_d);
    z_wr_addr_d = z_wr_addr_q;
    z_din_d     = z_din_q;
    if (state_q == LAST) begin
      z_wr_addr_d = ADDR_WIDTH'(i_q) * N_A + ADDR_WIDTH'(j_q);
      z_din_d     = mac_acc_next + z_prev_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_mode_q  <= 1'b0;
      zcap_q      <= 1'b0;
      z_prev_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      z_wr_en_q   <= 1'b0;
      x_addr_q    <= '0;
      y_addr_q    <= '0;
      z_rd_addr_q <= '0;
      z_wr_addr_q <= '0;
      z_din_q     <= '0;
    end else begin
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      acc_mode_q  <= acc_mode_d;
      zcap_q      <= zcap_d;
      z_prev_q    <= z_prev_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      z_wr_en_q   <= z_wr_en_d;
      x_addr_q    <= x_addr_d;
      y_addr_q    <= y_addr_d;
      z_rd_addr_q <= z_rd_addr_d;
      z_wr_addr_q <= z_wr_addr_d;
      z_din_q     <= z_din_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign z_wr_en   = z_wr_en_q;
  assign x_addr    = x_addr_q;
  assign y_addr    = y_addr_q;
  assign z_rd_addr = z_rd_addr_q;
  assign z_wr_addr = z_wr_addr_q;
  assign z_din     = z_din_q;

endmodule

// File: tb/tb_matmul_engine.sv
// tb/tb_matmul_engine.sv - directed checks on a 2x2x2 instance (a_) and a 2x3x4 instance (b_)
module tb_matmul_engine;
  localparam int DW = 32;
  localparam int AW = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  logic          a_start, a_acc, a_busy, a_done, a_zwe;
  logic [AW-1:0] a_xa, a_ya, a_zra, a_zwa;
  logic [DW-1:0] a_xd, a_yd, a_zrd, a_zdin;
  logic [DW-1:0] a_xm [64];
  logic [DW-1:0] a_ym [64];
  logic [DW-1:0] a_zm [64];
  int            a_wcnt = 0;

  logic          b_start, b_acc, b_busy, b_done, b_zwe;
  logic [AW-1:0] b_xa, b_ya, b_zra, b_zwa;
  logic [DW-1:0] b_xd, b_yd, b_zrd, b_zdin;
  logic [DW-1:0] b_xm [64];
  logic [DW-1:0] b_ym [64];
  logic [DW-1:0] b_zm [64];
  logic [AW-1:0] b_wlog [256];
  int            b_wcnt = 0;

  matmul_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .M_SIZE(2), .K_SIZE(2), .N_SIZE(2)) dut_a (
    .clock(clock), .reset(reset), .start(a_start), .accumulate(a_acc),
    .busy(a_busy), .done(a_done),
    .x_addr(a_xa), .x_dout(a_xd), .y_addr(a_ya), .y_dout(a_yd),
    .z_rd_addr(a_zra), .z_rd_dout(a_zrd),
    .z_wr_addr(a_zwa), .z_din(a_zdin), .z_wr_en(a_zwe)
  );

  matmul_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .M_SIZE(2), .K_SIZE(3), .N_SIZE(4)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .accumulate(b_acc),
    .busy(b_busy), .done(b_done),
    .x_addr(b_xa), .x_dout(b_xd), .y_addr(b_ya), .y_dout(b_yd),
    .z_rd_addr(b_zra), .z_rd_dout(b_zrd),
    .z_wr_addr(b_zwa), .z_din(b_zdin), .z_wr_en(b_zwe)
  );

  always @(posedge clock) begin
    a_xd  <= a_xm[a_xa];
    a_yd  <= a_ym[a_ya];
    a_zrd <= a_zm[a_zra];
    if (a_zwe) begin
      a_zm[a_zwa] <= a_zdin;
      a_wcnt      <= a_wcnt + 1;
    end
  end

  always @(posedge clock) begin
    b_xd  <= b_xm[b_xa];
    b_yd  <= b_ym[b_ya];
    b_zrd <= b_zm[b_zra];
    if (b_zwe) begin
      b_zm[b_zwa]    <= b_zdin;
      b_wlog[b_wcnt] <= b_zwa;
      b_wcnt         <= b_wcnt + 1;
    end
  end

  task automatic drive_start(input bit sel, input bit s, input bit acc);
    if (sel) begin b_start = s; b_acc = acc; end
    else begin a_start = s; a_acc = acc; end
  endtask

  // Starts one operation; cycle 1 is the cycle right after the edge that samples start.
  task automatic run_op(input bit sel, input bit acc, input int pulse_at,
                        output int done_cyc, output int wr1_cyc, output logic busy1);
    done_cyc = -1;
    wr1_cyc  = -1;
    busy1    = 1'b0;
    @(negedge clock);
    drive_start(sel, 1'b1, acc);
    @(posedge clock);
    #1;
    drive_start(sel, 1'b0, 1'b0);
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (cyc == 1) busy1 = sel ? b_busy : a_busy;
      if (wr1_cyc < 0 && (sel ? b_zwe : a_zwe)) wr1_cyc = cyc;
      if (sel ? b_done : a_done) begin
        done_cyc = cyc;
        break;
      end
      drive_start(sel, cyc == pulse_at, cyc == pulse_at);
      @(posedge clock);
      #1;
    end
    drive_start(sel, 1'b0, 1'b0);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_vec += 8;
    if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    if (a_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", a_done); end
    if (a_zwe !== 1'b0) begin n_bad++; $display("FAIL reset_z_wr_en: got %b expected 0", a_zwe); end
    if (a_xa !== '0) begin n_bad++; $display("FAIL reset_x_addr: got %0d expected 0", a_xa); end
    if (a_ya !== '0) begin n_bad++; $display("FAIL reset_y_addr: got %0d expected 0", a_ya); end
    if (a_zra !== '0) begin n_bad++; $display("FAIL reset_z_rd_addr: got %0d expected 0", a_zra); end
    if (a_zwa !== '0) begin n_bad++; $display("FAIL reset_z_wr_addr: got %0d expected 0", a_zwa); end
    if (a_zdin !== '0) begin n_bad++; $display("FAIL reset_z_din: got %0d expected 0", a_zdin); end
    reset = 1'b0;
  endtask

  task automatic test_identity();
    int dc, wc, w0;
    logic b1;
    int exp_z [4] = '{1, 2, 3, 4};
    a_xm[0] = 1; a_xm[1] = 2; a_xm[2] = 3; a_xm[3] = 4;
    a_ym[0] = 1; a_ym[1] = 0; a_ym[2] = 0; a_ym[3] = 1;
    w0 = a_wcnt;
    run_op(1'b0, 1'b0, -1, dc, wc, b1);
    n_vec += 4;
    if (dc != 17) begin n_bad++; $display("FAIL identity_done_cycle: got %0d expected 17", dc); end
    if (wc != 4) begin n_bad++; $display("FAIL identity_first_write: got %0d expected 4", wc); end
    if (b1 !== 1'b1) begin n_bad++; $display("FAIL identity_busy: got %b expected 1", b1); end
    if (a_wcnt - w0 != 4) begin n_bad++; $display("FAIL identity_writes: got %0d expected 4", a_wcnt - w0); end
    for (int e = 0; e < 4; e++) begin
      n_vec++;
      if (a_zm[e] !== 32'(exp_z[e])) begin
        n_bad++; $display("FAIL identity_z%0d: got %0d expected %0d", e, a_zm[e], exp_z[e]);
      end
    end
  endtask

  // Issued immediately after test_identity returns: start lands in the cycle after done.
  task automatic test_back_to_back_accumulate();
    int dc, wc;
    logic b1;
    int exp_z [4] = '{2, 4, 6, 8};
    run_op(1'b0, 1'b1, -1, dc, wc, b1);
    n_vec++;
    if (dc != 17) begin n_bad++; $display("FAIL accum_done_cycle: got %0d expected 17", dc); end
    for (int e = 0; e < 4; e++) begin
      n_vec++;
      if (a_zm[e] !== 32'(exp_z[e])) begin
        n_bad++; $display("FAIL accum_z%0d: got %0d expected %0d", e, a_zm[e], exp_z[e]);
      end
    end
  endtask

  task automatic test_start_during_busy();
    int dc, wc, w0;
    logic b1;
    int exp_z [4] = '{1, 2, 3, 4};
    w0 = a_wcnt;
    run_op(1'b0, 1'b0, 6, dc, wc, b1);
    n_vec += 2;
    if (dc != 17) begin n_bad++; $display("FAIL busy_start_done_cycle: got %0d expected 17", dc); end
    if (a_wcnt - w0 != 4) begin n_bad++; $display("FAIL busy_start_writes: got %0d expected 4", a_wcnt - w0); end
    for (int e = 0; e < 4; e++) begin
      n_vec++;
      if (a_zm[e] !== 32'(exp_z[e])) begin
        n_bad++; $display("FAIL busy_start_z%0d: got %0d expected %0d", e, a_zm[e], exp_z[e]);
      end
    end
  endtask

  task automatic test_wrap_sign();
    int dc, wc;
    logic b1;
    a_xm[0] = 32'h7FFF_FFFF; a_xm[1] = 32'hFFFF_FFFF; a_xm[2] = 0; a_xm[3] = 0;
    a_ym[0] = 2; a_ym[1] = 0; a_ym[2] = 3; a_ym[3] = 0;
    run_op(1'b0, 1'b0, -1, dc, wc, b1);
    n_vec += 2;
    if (a_zm[0] !== 32'hFFFF_FFFB) begin n_bad++; $display("FAIL wrap_z0: got %h expected fffffffb", a_zm[0]); end
    if (a_zm[3] !== 32'h0) begin n_bad++; $display("FAIL wrap_z3: got %h expected 00000000", a_zm[3]); end
  endtask

  task automatic test_reset_mid_run();
    int w0;
    logic busy_seen;
    for (int i = 0; i < 6; i++) b_xm[i] = i + 1;
    for (int i = 0; i < 12; i++) b_ym[i] = i + 1;
    w0 = b_wcnt;
    @(negedge clock);
    b_start = 1'b1;
    @(posedge clock);
    #1;
    b_start = 1'b0;
    // Element 3 is read during cycles 16..18; reset is sampled at the end of cycle 17.
    repeat (16) @(posedge clock);
    #1;
    reset = 1'b1;
    b_start = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    b_start = 1'b0;
    busy_seen = b_busy;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      busy_seen |= b_busy;
    end
    n_vec += 2;
    if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL reset_mid_busy: got %b expected 0", busy_seen); end
    if (b_wcnt - w0 != 3) begin n_bad++; $display("FAIL reset_mid_writes: got %0d expected 3", b_wcnt - w0); end
    for (int e = 0; e < 3; e++) begin
      n_vec++;
      if (b_wlog[w0 + e] !== AW'(e)) begin
        n_bad++; $display("FAIL reset_mid_addr%0d: got %0d expected %0d", e, b_wlog[w0 + e], e);
      end
    end
  endtask

  task automatic test_non_square();
    int dc, wc, w0;
    logic b1;
    int exp_z [8] = '{38, 44, 50, 56, 83, 98, 113, 128};
    w0 = b_wcnt;
    run_op(1'b1, 1'b0, -1, dc, wc, b1);
    n_vec += 3;
    if (dc != 41) begin n_bad++; $display("FAIL nonsq_done_cycle: got %0d expected 41", dc); end
    if (wc != 5) begin n_bad++; $display("FAIL nonsq_first_write: got %0d expected 5", wc); end
    if (b_wcnt - w0 != 8) begin n_bad++; $display("FAIL nonsq_writes: got %0d expected 8", b_wcnt - w0); end
    for (int e = 0; e < 8; e++) begin
      n_vec += 2;
      if (b_zm[e] !== 32'(exp_z[e])) begin
        n_bad++; $display("FAIL nonsq_z%0d: got %0d expected %0d", e, b_zm[e], exp_z[e]);
      end
      if (b_wlog[w0 + e] !== AW'(e)) begin
        n_bad++; $display("FAIL nonsq_order%0d: got %0d expected %0d", e, b_wlog[w0 + e], e);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    a_start = 1'b0; a_acc = 1'b0;
    b_start = 1'b0; b_acc = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a_xm[i] = '0; a_ym[i] = '0;
      b_xm[i] = '0; b_ym[i] = '0;
    end
    test_reset();
    test_identity();
    test_back_to_back_accumulate();
    test_start_during_busy();
    test_wrap_sign();
    test_reset_mid_run();
    test_non_square();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised successor to the fixed square matmul core: computes Z = X·Y, or Z = Z + X·Y in accumulate mode, for a non-square X (M×K) and Y (K×N). Operands are read from, and results written to, external single-port-per-direction BRAMs with registered (1-cycle) reads. The engine sits inside the matmul top level between the X, Y and Z BRAM instances. While `busy` is high, the engine owns the Z read port via a top-level mux.

## Interface
- `DATA_WIDTH`, 32: element width; signed two's complement.
- `ADDR_WIDTH`, 6: BRAM address width. Elaboration fails unless M·K, K·N and M·N are each ≤ 2^ADDR_WIDTH.
- `M_SIZE`, 8: rows of X and Z.
- `K_SIZE`, 8: columns of X and rows of Y; must be ≥ 1.
- `N_SIZE`, 8: columns of Y and Z.

Ports:
- `clock`  in  1: single clock; all logic rising-edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin an operation. Sampled only in IDLE.
- `accumulate`  in  1: mode select, sampled with `start`. 1 selects Z += X·Y.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse when the operation completes.
- `x_addr`  out  ADDR_WIDTH: X read address. X is row-major, element (i,k) at i·K+k.
- `x_dout`  in  DATA_WIDTH: X read data, valid 1 cycle after `x_addr`.
- `y_addr`  out  ADDR_WIDTH: Y read address. Y is row-major, element (k,j) at k·N+j.
- `y_dout`  in  DATA_WIDTH: Y read data, valid 1 cycle after `y_addr`.
- `z_rd_addr`  out  ADDR_WIDTH: Z read address, used in accumulate mode only.
- `z_rd_dout`  in  DATA_WIDTH: Z read data, valid 1 cycle after `z_rd_addr`.
- `z_wr_addr`  out  ADDR_WIDTH: Z write address, i·N+j.
- `z_din`  out  DATA_WIDTH: Z write data.
- `z_wr_en`  out  1: Z write strobe.

## Operation
- **State machine:** IDLE → READ → LAST → WRITE → (READ | DONE) → IDLE.
- **IDLE:**
  - `start`=1 latches `accumulate` into `acc_mode`.
  - Clears i, j, k and the accumulator.
  - Goes to READ.
- **READ (K cycles):**
  - Drives `x_addr`=i·K+k and `y_addr`=k·N+j.
  - From the 2nd READ cycle on, adds `x_dout`·`y_dout` (issued the previous cycle) to the accumulator.
  - k increments each cycle; at k=K−1 the state goes to LAST.
  - On the first READ cycle of each element, drives `z_rd_addr`=i·N+j. `z_rd_dout` is captured the following cycle into `z_prev`, or 0 when `acc_mode`=0.
- **LAST (1 cycle):** adds the final product. For K=1, READ is one cycle and LAST performs the only add.
- **WRITE (1 cycle):**
  - `z_wr_en`=1, `z_wr_addr`=i·N+j, `z_din`=accumulator+`z_prev`.
  - Clears the accumulator and k.
  - Advances j; when j wraps to 0, advances i.
  - After element (M−1,N−1), goes to DONE; otherwise goes to READ.
- **DONE (1 cycle):** `done`=1, then IDLE.
- **Arithmetic:**
  - Product is the low DATA_WIDTH bits of the signed product.
  - Accumulation wraps modulo 2^DATA_WIDTH, with no saturation.
  - Results are bit-exact to a wrapping 32-bit C int loop.
- **Boundary conditions:**
  - `start` while not in IDLE is ignored. `accumulate` is ignored outside the `start` cycle.
  - `reset` in any state forces IDLE next cycle and clears counters, accumulator and `z_prev`. No `z_wr_en` is asserted on or after the reset cycle. A partially written Z remains in the BRAM.
  - `start` and `reset` high together: `reset` wins.
  - Host writes to X/Y during `busy` are not prevented. Results are undefined in that case.

## Timing
- **Reset values:** `busy`=0, `done`=0, `z_wr_en`=0. `x_addr`, `y_addr`, `z_rd_addr`, `z_wr_addr` and `z_din` are all 0.
- **Start and busy:** `start` sampled at edge t0. `busy`=1 from t0+1 until the DONE cycle inclusive.
- **Per element:** K+2 cycles. The first `z_wr_en` occurs at cycle t0+K+2.
- **Total latency:** `done` occurs at t0 + M·N·(K+2) + 1.
- **Back-to-back:** earliest next accepted `start` is the cycle after `done`.
- **Outputs:** all registered, with no combinational path from inputs to outputs.
- **Accumulate-mode hazard:** a Z read of element e occurs after the write of element e−1 to a different address, so there is no read-after-write hazard.

## Structure
- **Package `matmul_pkg`:**
  - `state_t` enum: IDLE, READ, LAST, WRITE, DONE.
  - `clog2`-based counter width constants for i, j and k.
  - Shared by the engine and its top level.
- **Sub-module `mac_unit`:**
  - Signed DATA_WIDTH multiply.
  - Accumulator register with `clear` and `en`, using wrapping add.
  - The FSM and address generation remain in `matmul_engine`.

## Test plan
- **Identity, non-accumulate:** M=K=N=2, X=[1,2;3,4], Y=identity. Expect Z=[1,2;3,4], four `z_wr_en` pulses, `done` at t0+17.
- **Non-square:** M=2, K=3, N=4, X=[1..6], Y=[1..12]. Expect Z=[38,44,50,56; 83,98,113,128], written in row-major address order 0..7.
- **Accumulate:** run the identity case above, then `start` with `accumulate`=1 on the same data. Expect Z=[2,4;6,8].
- **Wrap and sign:** DATA_WIDTH=32, K=2, X row=[0x7FFFFFFF,−1], Y column=[2,3]. Expect `z_din`=0xFFFFFFFB.
- **Start during busy:** pulse `start` mid-run. Expect no restart, identical results and unchanged `done` timing.
- **Reset mid-run:** assert `reset` during the READ of element 3. Expect `busy`=0 and no `z_wr_en` thereafter. A fresh `start` then gives the correct full result.
